// File: rtl/i2s_rx.sv
// Philips-standard I2S receiver: BCLK/LRCLK/SDA oversampled on clk_i, one {left,right} sample per frame.
// Latency 3 clk_i edges from BCLK capture to valid_o/err_o; no backpressure, consumer must accept every valid_o pulse.
module i2s_rx #(
    parameter int WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 aud_bclk_i,
    input  logic                 aud_lrclk_i,
    input  logic                 aud_sda_i,
    output logic [2*WIDTH-1:0]   sample_o,
    output logic                 valid_o,
    output logic                 err_o,
    output logic                 sync_o
);
    localparam int CW = $clog2(4 * WIDTH);

    typedef enum logic {SYNC, RUN} state_t;

    state_t           state;
    logic             bclk_s0, bclk_s1, bclk_h;
    logic             lr_s0, lr_s1;
    logic             sda_s0, sda_s1;
    logic             lr_prev;
    logic             primed;
    logic             left_ok;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] left_hold;
    logic [CW-1:0]    cnt;

    logic             rise;
    logic             word_end;
    logic             long_word;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] word;

    always_comb begin
        rise      = bclk_s1 & ~bclk_h;
        sr_next   = {sr[WIDTH-2:0], sda_s1};
        word      = (cnt < CW'(WIDTH)) ? sr_next : sr;
        long_word = (cnt >= CW'(WIDTH - 1));
        // No rise has been seen since reset until primed is set, so lr_prev carries no history yet.
        word_end  = rise & primed & (lr_s1 != lr_prev);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= SYNC;
            bclk_s0   <= 1'b0;
            bclk_s1   <= 1'b0;
            bclk_h    <= 1'b0;
            lr_s0     <= 1'b0;
            lr_s1     <= 1'b0;
            sda_s0    <= 1'b0;
            sda_s1    <= 1'b0;
            lr_prev   <= 1'b0;
            primed    <= 1'b0;
            left_ok   <= 1'b0;
            sr        <= '0;
            left_hold <= '0;
            cnt       <= '0;
            sample_o  <= '0;
            valid_o   <= 1'b0;
            err_o     <= 1'b0;
            sync_o    <= 1'b0;
        end else begin
            bclk_s0 <= aud_bclk_i;
            bclk_s1 <= bclk_s0;
            bclk_h  <= bclk_s1;
            lr_s0   <= aud_lrclk_i;
            lr_s1   <= lr_s0;
            sda_s0  <= aud_sda_i;
            sda_s1  <= sda_s0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;

            if (rise) begin
                lr_prev <= lr_s1;
                primed  <= 1'b1;
                if (cnt < CW'(WIDTH)) begin
                    sr <= sr_next;
                end
                if (cnt != '1) begin
                    cnt <= cnt + CW'(1);
                end

                if (word_end) begin
                    cnt <= '0;
                    if (state == SYNC) begin
                        state  <= RUN;
                        sync_o <= 1'b1;
                    end else if (!long_word) begin
                        err_o   <= 1'b1;
                        left_ok <= 1'b0;
                    end else if (!lr_prev) begin
                        left_hold <= word;
                        left_ok   <= 1'b1;
                    end else if (left_ok) begin
                        sample_o <= {left_hold, word};
                        valid_o  <= 1'b1;
                        left_ok  <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_rx.sv
// Randomised and directed I2S frames checked against a slot-level reference model.
module tb_i2s_rx;
    localparam int WIDTH = 16;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              aud_bclk_i = 1'b0;
    logic              aud_lrclk_i = 1'b0;
    logic              aud_sda_i = 1'b0;
    logic [2*WIDTH-1:0] sample_o;
    logic              valid_o;
    logic              err_o;
    logic              sync_o;

    i2s_rx #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .aud_bclk_i  (aud_bclk_i),
        .aud_lrclk_i (aud_lrclk_i),
        .aud_sda_i   (aud_sda_i),
        .sample_o    (sample_o),
        .valid_o     (valid_o),
        .err_o       (err_o),
        .sync_o      (sync_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A slot is one channel's LRCLK phase; bits are sent MSB first from bits[31].
    typedef struct {
        bit          lr;
        int          len;
        logic [31:0] bits;
    } slot_t;

    typedef struct {
        bit          is_err;
        logic [31:0] smp;
    } ev_t;

    ev_t         exp_q[$];
    bit          m_sync = 0;
    bit          m_left_ok = 0;
    logic [15:0] m_left = '0;

    // Reference: what the receiver must report when a slot closes.
    task automatic model_end(input slot_t s);
        ev_t e;
        if (!m_sync) begin
            m_sync = 1;
        end else if (s.len < WIDTH) begin
            e.is_err = 1;
            e.smp    = '0;
            exp_q.push_back(e);
            m_left_ok = 0;
        end else if (!s.lr) begin
            m_left    = s.bits[31:16];
            m_left_ok = 1;
        end else if (m_left_ok) begin
            e.is_err = 0;
            e.smp    = {m_left, s.bits[31:16]};
            exp_q.push_back(e);
            m_left_ok = 0;
        end
    endtask

    slot_t prev_slot;
    bit    have_prev = 0;
    bit    carry = 0;

    task automatic drive_period(input bit lr, input bit sda, input int half, input bit do_rst);
        aud_bclk_i  = 1'b0;
        aud_lrclk_i = lr;
        aud_sda_i   = sda;
        for (int i = 0; i < half; i++) begin
            @(negedge clk_i);
            rst_i = do_rst && (i == 0);
        end
        aud_bclk_i = 1'b1;
        repeat (half) @(negedge clk_i);
    endtask

    // Philips format: each slot's data is delayed one BCLK, so its LSB lands in the next slot's first period.
    task automatic play_slot(input slot_t s, input int half, input int rst_at);
        for (int p = 0; p < s.len; p++) begin
            bit b;
            if (p == 0 && have_prev) model_end(prev_slot);
            b = (p == 0) ? carry : s.bits[32-p];
            if (p == rst_at) begin
                m_sync    = 0;
                m_left_ok = 0;
            end
            drive_period(s.lr, b, half, p == rst_at);
        end
        carry     = s.bits[32-s.len];
        prev_slot = s;
        have_prev = 1;
    endtask

    task automatic play_frame(input logic [31:0] lb, input int ll, input logic [31:0] rb,
                              input int rl, input int half, input int rst_r);
        slot_t s;
        s.lr = 0; s.len = ll; s.bits = lb;
        play_slot(s, half, -1);
        s.lr = 1; s.len = rl; s.bits = rb;
        play_slot(s, half, rst_r);
    endtask

    // Output monitor, sampled 1 time unit after each active edge.
    logic [31:0] last_smp = '0;
    bit          prev_vld = 0;

    always @(posedge clk_i) begin
        #1;
        if (rst_i) begin
            check("rst_sample", sample_o, 0);
            check("rst_valid", valid_o, 0);
            check("rst_err", err_o, 0);
            check("rst_sync", sync_o, 0);
            last_smp = '0;
            prev_vld = 0;
        end else begin
            if (valid_o || err_o) begin
                check("vld_err_excl", valid_o & err_o, 0);
                check("evt_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("evt_kind_err", err_o, e.is_err);
                    if (!e.is_err) check("sample", sample_o, e.smp);
                end
            end
            if (valid_o) begin
                check("vld_width", prev_vld, 0);
                last_smp = sample_o;
            end else begin
                check("hold", sample_o, last_smp);
            end
            prev_vld = valid_o;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk_i);
        rst_i = 1'b0;

        // Basic frames: first is consumed by alignment, then one valid per frame.
        for (int i = 0; i < 4; i++) play_frame({16'hA5C3, 16'h0}, 16, {16'h1234, 16'h0}, 16, 4, -1);
        check("sync_basic", sync_o, m_sync);

        // Channel mapping and LSB delay slot.
        for (int i = 0; i < 2; i++) begin
            play_frame({16'h8001, 16'h0}, 16, {16'h7FFE, 16'h0}, 16, 4, -1);
            play_frame({16'h0000, 16'h0}, 16, {16'hFFFF, 16'h0}, 16, 4, -1);
        end

        // 32-BCLK slots keep the upper WIDTH bits.
        for (int i = 0; i < 2; i++) play_frame({16'h1357, 16'hFFFF}, 32, {16'h2468, 16'hFFFF}, 32, 4, -1);

        // Truncated left word, then recovery.
        play_frame({16'hABCD, 16'h0}, 12, {16'h6789, 16'h0}, 16, 4, -1);
        for (int i = 0; i < 2; i++) play_frame({16'h5A5A, 16'h0}, 16, {16'hC3C3, 16'h0}, 16, 4, -1);
        check("sync_short", sync_o, m_sync);

        // Reset during bit 7 of a right word.
        play_frame({16'h1111, 16'h0}, 16, {16'h2222, 16'h0}, 16, 4, 7);
        for (int i = 0; i < 2; i++) play_frame({16'h3333, 16'h0}, 16, {16'h4444, 16'h0}, 16, 4, -1);
        check("sync_rst", sync_o, m_sync);

        // Fastest BCLK.
        for (int i = 0; i < 3; i++) play_frame({16'hFFFF, 16'h0}, 16, {16'h0001, 16'h0}, 16, 2, -1);

        // Random words, slot lengths and BCLK rates, including short words.
        for (int i = 0; i < 10; i++) begin
            int h, ll, rl;
            h  = $urandom_range(2, 5);
            ll = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 15) : $urandom_range(16, 32);
            rl = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 15) : $urandom_range(16, 32);
            play_frame($urandom, ll, $urandom, rl, h, -1);
        end

        // Closing left slot ends the final right word.
        begin
            slot_t s;
            s.lr = 0; s.len = 16; s.bits = 32'h0;
            play_slot(s, 4, -1);
        end
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk_i);
        check("drain", exp_q.size(), 0);
        check("sync_end", sync_o, m_sync);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/i2s_rx.md
# i2s_rx

Philips-standard I2S receiver for the audio path. It is the capture-side counterpart of the I2S transmitter. It takes BCLK, LRCLK and SDA from an external codec/ADC, which acts as I2S controller. All three inputs are oversampled in the system clock domain, and the block emits one {left, right} sample per frame with a single-cycle valid pulse. It sits between the codec pins and the audio sample consumer (FIFO or DSP), and runs entirely on clk_i.

## Interface
- WIDTH, 16, bits per channel word delivered; sample_o is 2*WIDTH wide
- clk_i  in  1  system clock; must be at least 4x BCLK, with BCLK high and low phases each at least 2 clk_i periods
- rst_i  in  1  synchronous, active-high reset
- aud_bclk_i  in  1  I2S bit clock, asynchronous to clk_i
- aud_lrclk_i  in  1  I2S word select, asynchronous; 0 = left, 1 = right
- aud_sda_i  in  1  I2S serial data, asynchronous, MSB first
- sample_o  out  2*WIDTH  last complete frame, {left[WIDTH-1:0], right[WIDTH-1:0]}; held between frames
- valid_o  out  1  one-cycle pulse; sample_o updated in the same cycle
- err_o  out  1  one-cycle pulse; a channel word had fewer than WIDTH bits
- sync_o  out  1  level; high once word alignment is acquired

## Operation
- **Input synchronisation:** each input passes through a 2-FF synchroniser (s0, s1) plus one history flop on BCLK.
  - rise = bclk_s1 & ~bclk_h.
  - LRCLK and SDA are used only at rise, taken from their s1 stages, which keeps all three equally delayed.
- **Registers:** lr_prev is LRCLK at the previous rise. Also held: shift register sr[WIDTH-1:0], bit counter cnt (saturating, width clog2(4*WIDTH)), left_hold[WIDTH-1:0], and left_ok.
- **Philips alignment:** LRCLK changes on a BCLK falling edge. SDA in the same BCLK period carries the LSB of the outgoing channel, and the MSB of the new channel follows one BCLK later.
- **Shift rule:** on every rise with cnt < WIDTH, sr <= {sr[WIDTH-2:0], sda}. cnt increments on every rise and saturates at all-ones.
  - Bits beyond WIDTH are ignored, so longer slots (e.g. 32 BCLK per channel) keep the upper WIDTH bits.
- **Word end:** a rise where lrclk != lr_prev closes the word. That rise's SDA bit is included, so the word length is cnt+1, and its channel is lr_prev.
- **State machine:**
  - **SYNC** (reset state, sync_o=0):
    - Shifting runs, but words are discarded.
    - On the first word end, cnt <= 0, lr_prev updates, go to RUN.
    - No err_o in this state.
  - **RUN** (sync_o=1), on each word end:
    - **Length >= WIDTH, lr_prev=0:** left_hold <= word, left_ok <= 1.
    - **Length >= WIDTH, lr_prev=1, left_ok=1:** sample_o <= {left_hold, word}, valid_o pulses, left_ok <= 0.
    - **Length >= WIDTH, lr_prev=1, left_ok=0:** the right word is discarded silently.
    - **Length < WIDTH:** err_o pulses, left_ok <= 0, word discarded, and the block stays in RUN.
    - cnt <= 0 after every word end.
    - **"word" definition:** the word is the value sr will hold after this rise's shift, when cnt < WIDTH. Otherwise it is the current sr.
- **Saturation:** cnt saturating with no word end (LRCLK stuck) produces no output and no error.
- **Reset values:** rst_i at any time, including mid-word, returns to SYNC and clears the following to 0:
  - sample_o, valid_o, err_o, sync_o
  - cnt, sr, left_hold, left_ok
  - lr_prev, all synchroniser and history flops

## Timing
- A BCLK rising edge first captured in s0 at clk_i edge N is detected as rise in the cycle after edge N+1. State updates at edge N+2.
- valid_o and err_o are high for exactly the cycle following edge N+2, i.e. 3 clk_i edges after capture.
- sample_o changes at the same edge valid_o rises, and is stable until the next valid_o.
- Frame-to-frame latency is 1 frame. Left is captured at the right-channel MSB rise region; output follows the first rise with LRCLK=0 after the right word.
- Maximum valid_o rate is one per LRCLK period. valid_o and err_o are never asserted in the same cycle.

## Test plan
- **Basic frame:** WIDTH=16, BCLK=clk_i/8, Philips-formatted frames left=0xA5C3, right=0x1234, repeated.
  - First frame is consumed by SYNC.
  - Then sample_o=0xA5C31234 with one valid_o per frame; sync_o=1; err_o never asserts.
- **Channel mapping:** alternating frames {0x8001,0x7FFE} and {0x0000,0xFFFF} -> sample_o sequence 0x80017FFE, 0x0000FFFF; checks MSB/LSB placement and the LSB delay slot.
- **32-BCLK slots:** WIDTH=16 with 32 BCLK per channel, top 16 bits left=0x1357, right=0x2468, lower 16 bits 0xFFFF -> sample_o=0x13572468.
- **Short word:** one left word truncated to 12 BCLK -> single err_o pulse; no valid_o for that frame; next good frame yields correct sample_o.
- **Reset mid-word:** assert rst_i for 1 cycle during bit 7 of a right word.
  - All outputs are 0 and sync_o=0 from the next cycle.
  - The partial word and the next word end produce no valid_o or err_o.
  - The following full frame yields correct sample_o.
- **Pulse-width check:** BCLK=clk_i/4, frames {0xFFFF,0x0001} -> correct sample_o; valid_o is always exactly 1 cycle wide.
